// File: rtl/sm4_pkg.sv
// sm4_pkg: shared types, constant tables and the nonlinear/linear helper
// functions of the SM4 block cipher.
//   SBOX - 8-bit substitution table
//   FK   - key-schedule whitening constants
//   CK   - key-schedule round constants
//   tau  - byte-wise S-box over a 32-bit word
//   l_enc / l_key - linear diffusion for the data path / key schedule
package sm4_pkg;

  typedef enum logic [1:0] {
    MODE_ECB = 2'd0,
    MODE_CBC = 2'd1,
    MODE_CTR = 2'd2,
    MODE_RSV = 2'd3
  } sm4_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_READY,
    ST_RUN,
    ST_OUT
  } sm4_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  // x ^ x<<<2 ^ x<<<10 ^ x<<<18 ^ x<<<24
  function automatic logic [31:0] l_enc(input logic [31:0] x);
    return x ^ {x[29:0], x[31:30]} ^ {x[21:0], x[31:22]} ^ {x[13:0], x[31:14]} ^ {x[7:0], x[31:8]};
  endfunction

  // x ^ x<<<13 ^ x<<<23
  function automatic logic [31:0] l_key(input logic [31:0] x);
    return x ^ {x[18:0], x[31:19]} ^ {x[8:0], x[31:9]};
  endfunction

endpackage

// File: rtl/sm4_cipher_core_round.sv
// sm4_round: one combinational SM4 round over a 4-word state.
//   key_sel_i  0 = data round (l_enc), 1 = key-schedule round (l_key)
//   x_i        state {W0,W1,W2,W3}, W0 in [127:96]
//   rk_i       round key (data) or CK constant (key schedule)
//   x_o        next state {W1,W2,W3,W4}; W4 is the new word in [31:0]
module sm4_round
  import sm4_pkg::*;
(
  input  logic         key_sel_i,
  input  logic [127:0] x_i,
  input  logic [31:0]  rk_i,
  output logic [127:0] x_o
);

  logic [31:0] t_w;
  logic [31:0] f_w;

  assign t_w = tau(x_i[95:64] ^ x_i[63:32] ^ x_i[31:0] ^ rk_i);
  assign f_w = key_sel_i ? l_key(t_w) : l_enc(t_w);
  assign x_o = {x_i[95:0], x_i[127:96] ^ f_w};

endmodule

// File: rtl/sm4_cipher_core.sv
// sm4_cipher_core: streaming SM4 engine with ECB/CBC/CTR chaining.
//   clk, rst                 clock, synchronous active-high reset
//   key_valid/key_ready      key load handshake; key, iv, mode, decrypt sampled
//   in_valid/in_ready/in_data  input block handshake
//   out_valid/out_ready/out_data result handshake; data held until consumed
//   error                    with out_valid: block dropped, out_data = 0
//   busy                     high outside IDLE and READY
// RPC rounds are evaluated per clock, so key expansion and each block take
// 32/RPC cycles. Round keys are cached until the next key load.
module sm4_cipher_core
  import sm4_pkg::*;
#(
  parameter int RPC       = 1,
  parameter int CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic [1:0]   mode,
  input  logic         decrypt,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         error,
  output logic         busy
);

  localparam int NCYC = 32 / RPC;
  localparam int CW   = $clog2(NCYC);
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

  sm4_state_e   state_q, state_d;
  sm4_mode_e    mode_q;
  logic         dec_q, key_loaded_q;
  logic         key_ready_q, in_ready_q, out_valid_q, busy_q, error_q;
  logic [127:0] out_data_q, chain_q, ctr_q, k_q, x_q, din_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]  rk_q [32];

  logic         key_hs, in_hs, out_hs, bad_w, last_w, run_dec;
  logic [127:0] dx [RPC+1];
  logic [127:0] kx [RPC+1];
  logic [31:0]  drk [RPC];
  logic [4:0]   idx [RPC];
  logic [127:0] rev_w, res_w, ctr_inc;

  function automatic logic [127:0] rev_words(input logic [127:0] v);
    return {v[31:0], v[63:32], v[95:64], v[127:96]};
  endfunction

  // A key request wins over a simultaneous data request.
  assign key_hs  = key_valid & key_ready_q;
  assign in_hs   = in_valid & in_ready_q & ~key_hs;
  assign out_hs  = out_valid_q & out_ready;
  assign bad_w   = ~key_loaded_q | (mode_q == MODE_RSV);
  assign last_w  = (cnt_q == CW'(NCYC - 1));
  assign run_dec = dec_q & (mode_q != MODE_CTR);

  assign dx[0] = x_q;
  assign kx[0] = k_q;

  // Round chains: RPC data rounds and RPC key-schedule rounds per cycle
  for (genvar j = 0; j < RPC; j++) begin : g_rnd
    assign idx[j] = 5'(32'(cnt_q) * RPC + j);
    assign drk[j] = run_dec ? rk_q[5'd31 - idx[j]] : rk_q[idx[j]];
    sm4_round u_data (.key_sel_i(1'b0), .x_i(dx[j]), .rk_i(drk[j]),    .x_o(dx[j+1]));
    sm4_round u_key  (.key_sel_i(1'b1), .x_i(kx[j]), .rk_i(CK[idx[j]]), .x_o(kx[j+1]));
  end

  // Round key cache: entry i is produced in key-schedule cycle i/RPC
  for (genvar i = 0; i < 32; i++) begin : g_rk
    always_ff @(posedge clk) begin
      if (rst) begin
        rk_q[i] <= '0;
      end else if (state_q == ST_KEYEXP && cnt_q == CW'(i / RPC)) begin
        rk_q[i] <= kx[(i % RPC) + 1][31:0];
      end
    end
  end

  assign rev_w   = rev_words(dx[RPC]);
  assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

  always_comb begin
    res_w = rev_w;
    case (mode_q)
      MODE_CBC: res_w = dec_q ? (rev_w ^ chain_q) : rev_w;
      MODE_CTR: res_w = rev_w ^ din_q;
      default:  res_w = rev_w;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (key_hs)     state_d = ST_KEYEXP;
        else if (in_hs) state_d = bad_w ? ST_OUT : ST_RUN;
      end
      ST_KEYEXP: if (last_w) state_d = ST_READY;
      ST_RUN:    if (last_w) state_d = ST_OUT;
      ST_OUT:    if (out_hs) state_d = key_loaded_q ? ST_READY : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_ready_q  <= 1'b1;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      out_data_q   <= '0;
      key_loaded_q <= 1'b0;
      mode_q       <= MODE_ECB;
      dec_q        <= 1'b0;
      chain_q      <= '0;
      ctr_q        <= '0;
      k_q          <= '0;
      x_q          <= '0;
      din_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q     <= state_d;
      key_ready_q <= (state_d == ST_IDLE) || (state_d == ST_READY);
      in_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_READY);
      out_valid_q <= (state_d == ST_OUT);
      busy_q      <= (state_d != ST_IDLE) && (state_d != ST_READY);
      case (state_q)
        ST_IDLE, ST_READY: begin
          cnt_q <= '0;
          if (key_hs) begin
            k_q     <= key ^ {FK[0], FK[1], FK[2], FK[3]};
            chain_q <= iv;
            ctr_q   <= iv;
            mode_q  <= sm4_mode_e'(mode);
            dec_q   <= decrypt;
          end else if (in_hs) begin
            din_q   <= in_data;
            error_q <= bad_w;
            if (bad_w) out_data_q <= '0;
            case (mode_q)
              MODE_CBC: x_q <= dec_q ? in_data : (in_data ^ chain_q);
              MODE_CTR: x_q <= ctr_q;
              default:  x_q <= in_data;
            endcase
          end
        end
        ST_KEYEXP: begin
          k_q   <= kx[RPC];
          cnt_q <= cnt_q + 1'b1;
          if (last_w) key_loaded_q <= 1'b1;
        end
        ST_RUN: begin
          x_q   <= dx[RPC];
          cnt_q <= cnt_q + 1'b1;
          if (last_w) begin
            out_data_q <= res_w;
            if (mode_q == MODE_CBC) chain_q <= dec_q ? din_q : rev_w;
            if (mode_q == MODE_CTR) ctr_q <= ctr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_ready = key_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign error     = error_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sm4_cipher_core.sv
module tb_sm4_cipher_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, key_valid, decrypt, in_valid, out_ready, sel;
  logic [127:0] key, iv, in_data;
  logic [1:0]   mode;
  logic         kr1, ir1, ov1, er1, bz1, kr4, ir4, ov4, er4, bz4;
  logic [127:0] od1, od4;
  logic         kr, ir, ov, er, bz;
  logic [127:0] od;

  sm4_cipher_core #(.RPC(1), .CTR_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(kr1), .key(key), .iv(iv),
    .mode(mode), .decrypt(decrypt), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .error(er1), .busy(bz1));

  sm4_cipher_core #(.RPC(4), .CTR_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(kr4), .key(key), .iv(iv),
    .mode(mode), .decrypt(decrypt), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .error(er4), .busy(bz4));

  assign kr = sel ? kr4 : kr1;
  assign ir = sel ? ir4 : ir1;
  assign ov = sel ? ov4 : ov1;
  assign er = sel ? er4 : er1;
  assign bz = sel ? bz4 : bz1;
  assign od = sel ? od4 : od1;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] K0  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C0  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] CIV = 128'h000000000000000000000000ffffffff;

  localparam logic [7:0] SB [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] sub(input logic [31:0] v);
    return {SB[v[31:24]], SB[v[23:16]], SB[v[15:8]], SB[v[7:0]]};
  endfunction

  // Straight-line reference cipher: full key expansion then 32 rounds.
  function automatic logic [127:0] ref_sm4(input logic [127:0] k, input logic [127:0] b, input logic dec);
    logic [31:0] kk [36];
    logic [31:0] rk [32];
    logic [31:0] x [36];
    logic [31:0] t, ck;
    kk[0] = k[127:96] ^ 32'ha3b1bac6;  kk[1] = k[95:64] ^ 32'h56aa3350;
    kk[2] = k[63:32]  ^ 32'h677d9197;  kk[3] = k[31:0]  ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      t = sub(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck);
      kk[i+4] = kk[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
      rk[i] = kk[i+4];
    end
    x[0] = b[127:96]; x[1] = b[95:64]; x[2] = b[63:32]; x[3] = b[31:0];
    for (int i = 0; i < 32; i++) begin
      t = sub(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk[31-i] : rk[i]));
      x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  typedef struct {
    logic [127:0] key;
    logic [127:0] iv;
    logic [1:0]   mode;
    logic         dec;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vt [3];
  logic [127:0] P [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL [rpc=%0d] %s: got %h, expected %h", sel ? 4 : 1, name, act, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] v, input logic [1:0] m, input logic dc);
    int t;
    key = k; iv = v; mode = m; decrypt = dc; key_valid = 1'b1;
    t = 0;
    while (!kr && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    key_valid = 1'b0;
    t = 0;
    while (!ir && t < 100) begin @(posedge clk); #1; t++; end
    check("key_load_done", 128'(ir), 128'd1);
  endtask

  task automatic handshake_in(input logic [127:0] d);
    int t;
    in_data = d; in_valid = 1'b1;
    t = 0;
    while (!ir && t < 100) begin @(posedge clk); #1; t++; end
    check("in_ready_seen", 128'(ir), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic [127:0] d, output logic e);
    lat = 0;
    while (!ov && lat < 100) begin @(posedge clk); #1; lat++; end
    check("out_valid_seen", 128'(ov), 128'd1);
    d = od; e = er;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic run_suite();
    int lat, explat, bad_cnt;
    logic [127:0] d, d0, c [3];
    logic e, e0, seen;
    explat = sel ? 8 : 32;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_key_ready", 128'(kr), 128'd1);
    check("rst_in_ready", 128'(ir), 128'd0);
    check("rst_out_valid", 128'(ov), 128'd0);
    check("rst_busy", 128'(bz), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 128'(ir), 128'd1);

    // data with no key loaded
    handshake_in(P[0]);
    wait_out(lat, d, e);
    check("idle_err_flag", 128'(e), 128'd1);
    check("idle_err_data", d, 128'd0);
    check("idle_err_lat", 128'(lat), 128'd0);

    for (int i = 0; i < 3; i++) begin
      load_key(vt[i].key, vt[i].iv, vt[i].mode, vt[i].dec);
      handshake_in(vt[i].din);
      wait_out(lat, d, e);
      check($sformatf("vec%0d_data", i), d, vt[i].dout);
      check($sformatf("vec%0d_err", i), 128'(e), 128'd0);
      check($sformatf("vec%0d_lat", i), 128'(lat), 128'(explat));
    end

    // CBC encrypt then decrypt with reloaded IV
    load_key(K0, 128'd0, 2'd1, 1'b0);
    d0 = 128'd0;
    for (int i = 0; i < 3; i++) begin
      handshake_in(P[i]);
      wait_out(lat, d, e);
      c[i] = d;
      d0 = ref_sm4(K0, P[i] ^ d0, 1'b0);
      check($sformatf("cbc_enc%0d", i), d, d0);
    end
    check("cbc_enc0_kat", c[0], C0);
    load_key(K0, 128'd0, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      handshake_in(c[i]);
      wait_out(lat, d, e);
      check($sformatf("cbc_dec%0d", i), d, P[i]);
    end

    // CTR with low counter wrap; decrypt flag must be ignored
    load_key(K0, CIV, 2'd2, 1'b1);
    handshake_in(P[0]);
    wait_out(lat, d, e);
    check("ctr_blk0", d, P[0] ^ ref_sm4(K0, CIV, 1'b0));
    handshake_in(P[1]);
    wait_out(lat, d, e);
    check("ctr_blk1_wrap", d, P[1] ^ ref_sm4(K0, 128'd0, 1'b0));

    // reserved mode, then recovery
    load_key(K0, 128'd0, 2'd3, 1'b0);
    handshake_in(P[0]);
    wait_out(lat, d, e);
    check("rsv_err_flag", 128'(e), 128'd1);
    check("rsv_err_data", d, 128'd0);
    load_key(K0, 128'd0, 2'd0, 1'b0);
    handshake_in(P[0]);
    wait_out(lat, d, e);
    check("after_rsv_data", d, C0);
    check("after_rsv_err", 128'(e), 128'd0);

    // output back-pressure
    out_ready = 1'b0;
    handshake_in(P[0]);
    wait_out(lat, d0, e0);
    check("stall_data", d0, C0);
    bad_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (od !== d0 || er !== e0 || ir !== 1'b0 || ov !== 1'b1) bad_cnt++;
    end
    check("stall_hold", 128'(bad_cnt), 128'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_single_out", 128'(ov), 128'd0);
    handshake_in(P[1]);
    wait_out(lat, d, e);
    check("after_stall_data", d, ref_sm4(K0, P[1], 1'b0));

    // simultaneous key and data in READY
    key = K0; iv = 128'd0; mode = 2'd0; decrypt = 1'b0;
    key_valid = 1'b1; in_data = P[0]; in_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("both_busy", 128'(bz), 128'd1);
    check("both_in_stalled", 128'(ir), 128'd0);
    check("both_key_taken", 128'(kr), 128'd0);
    handshake_in(P[0]);
    wait_out(lat, d, e);
    check("both_data", d, C0);
    check("both_lat", 128'(lat), 128'(explat));

    // reset in the middle of a block
    handshake_in(P[0]);
    repeat (sel ? 4 : 10) @(posedge clk);
    #1;
    check("mid_busy", 128'(bz), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_key_ready", 128'(kr), 128'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov) seen = 1'b1;
    end
    check("mid_rst_no_out", 128'(seen), 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    key = '0; iv = '0; mode = 2'd0; decrypt = 1'b0; in_data = '0;
    P[0] = K0;
    P[1] = 128'h00112233445566778899aabbccddeeff;
    P[2] = 128'hdeadbeef0badf00dcafebabe12345678;
    vt[0] = '{key: K0, iv: 128'd0, mode: 2'd0, dec: 1'b0, din: K0, dout: C0};
    vt[1] = '{key: K0, iv: 128'd0, mode: 2'd0, dec: 1'b1, din: C0, dout: K0};
    vt[2] = '{key: P[1], iv: 128'd0, mode: 2'd0, dec: 1'b1, din: P[2], dout: ref_sm4(P[1], P[2], 1'b1)};
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      run_suite();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
